// File: rtl/beam_pkg.sv
// beam_pkg: state encoding, frame-length constants and helpers shared by the
// beam/sync receive path.
package beam_pkg;

  // Receiver lock state; ST_ prefix keeps the names clear of the LOCKED port
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_t;

  // Legal frame lengths in lines
  localparam logic [9:0] NTSC_SHORT = 10'd262;
  localparam logic [9:0] NTSC_LONG  = 10'd263;
  localparam logic [9:0] PAL_SHORT  = 10'd312;
  localparam logic [9:0] PAL_LONG   = 10'd313;

  // Frames at or above this length are reported as PAL
  localparam logic [9:0] PAL_MIN_LINES = 10'd300;

  // Master clock cycles per colour clock
  localparam int CYCLES_PER_CCK = 8;

  // True when a measured frame length is one of the four broadcast lengths
  function automatic logic is_legal_frame(input logic [9:0] lines);
    return (lines == NTSC_SHORT) || (lines == NTSC_LONG) ||
           (lines == PAL_SHORT)  || (lines == PAL_LONG);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers an active-low sync pad once and produces a
// one-cycle strobe for each falling edge seen on the registered sample.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic fall
);

  logic sample;

  // Sample the pad and flag a 1 -> 0 transition between successive samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sample <= pad;
      fall   <= sample & ~pad;
    end
  end

endmodule

// File: rtl/beam_sync_rx.sv
// beam_sync_rx: measures line period and frame length from the HSYNC/VSYNC
// pads, rebuilds the beam position, classifies the video standard and
// reports when the incoming timing is stable and legal.
module beam_sync_rx #(
  parameter int H_MIN      = 1800,
  parameter int H_MAX      = 1830,
  parameter int LOCK_COUNT = 4
) (
  input  logic        PAD_C28M,
  input  logic        PAD_NRST,
  input  logic        PAD_HSYNC,
  input  logic        PAD_VSYNC,
  output logic [11:0] HPOS,
  output logic [9:0]  VPOS,
  output logic [11:0] H_PERIOD,
  output logic [9:0]  V_LINES,
  output logic        LOCKED,
  output logic        PAL_DET,
  output logic        INTERLACE,
  output logic        ERR_PULSE
);

  import beam_pkg::*;

  localparam logic [12:0] H_MIN_CYC   = 13'(H_MIN);
  localparam logic [12:0] H_MAX_CYC   = 13'(H_MAX);
  localparam logic [4:0]  LOCK_TARGET = 5'(LOCK_COUNT);

  logic        hfall;
  logic        vfall;
  logic        hpos_sat;
  logic        vpos_sat;
  logic [12:0] hpos_inc;
  logic        line_bad;
  logic        frame_bad;
  logic        frame_bad_now;
  logic [10:0] vlines_sum;
  logic [9:0]  vlines_new;
  logic [9:0]  prev_lines;
  logic        lines_differ_by_one;
  logic        frame_valid;
  logic [3:0]  good_cnt;
  logic [4:0]  good_next;
  sync_state_t state;

  sync_edge_det u_hsync_det (
    .clk   (PAD_C28M),
    .rst_n (PAD_NRST),
    .pad   (PAD_HSYNC),
    .fall  (hfall)
  );

  sync_edge_det u_vsync_det (
    .clk   (PAD_C28M),
    .rst_n (PAD_NRST),
    .pad   (PAD_VSYNC),
    .fall  (vfall)
  );

  // A line closing on this HSYNC fall is judged on its length; a coincident
  // HSYNC fall belongs to the frame that the VSYNC fall is closing.
  assign hpos_sat      = (HPOS == 12'hFFF);
  assign vpos_sat      = (VPOS == 10'h3FF);
  assign hpos_inc      = {1'b0, HPOS} + 13'd1;
  assign line_bad      = hpos_sat || (hpos_inc < H_MIN_CYC) || (hpos_inc > H_MAX_CYC);
  assign frame_bad_now = frame_bad | (hfall & line_bad);
  assign vlines_sum    = {1'b0, VPOS} + {10'd0, hfall};
  assign vlines_new    = vlines_sum[10] ? 10'h3FF : vlines_sum[9:0];
  assign frame_valid   = !frame_bad_now && is_legal_frame(vlines_new);
  assign lines_differ_by_one = ({1'b0, vlines_new} == {1'b0, prev_lines} + 11'd1) ||
                               ({1'b0, prev_lines} == {1'b0, vlines_new} + 11'd1);
  assign good_next     = {1'b0, good_cnt} + 5'd1;

  // Beam position counters, line/frame measurements and the sticky bad-line flag
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      HPOS       <= 12'd0;
      VPOS       <= 10'd0;
      H_PERIOD   <= 12'd0;
      V_LINES    <= 10'd0;
      prev_lines <= 10'd0;
      frame_bad  <= 1'b0;
    end else begin
      if (hfall) begin
        HPOS     <= 12'd0;
        H_PERIOD <= hpos_inc[12] ? 12'hFFF : hpos_inc[11:0];
      end else if (!hpos_sat) begin
        HPOS <= HPOS + 12'd1;
      end

      if (vfall) begin
        VPOS <= 10'd0;
      end else if (hfall && !vpos_sat) begin
        VPOS <= VPOS + 10'd1;
      end

      if (vfall) begin
        V_LINES    <= vlines_new;
        prev_lines <= vlines_new;
        frame_bad  <= 1'b0;
      end else if (hfall && line_bad) begin
        frame_bad <= 1'b1;
      end
    end
  end

  // Lock state machine, stepped at each frame end, with registered status outputs
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      state     <= ST_SEARCH;
      good_cnt  <= 4'd0;
      LOCKED    <= 1'b0;
      PAL_DET   <= 1'b0;
      INTERLACE <= 1'b0;
      ERR_PULSE <= 1'b0;
    end else begin
      ERR_PULSE <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (vfall) begin
            state    <= ST_ACQUIRE;
            good_cnt <= 4'd0;
          end
        end
        ST_ACQUIRE: begin
          if (vfall) begin
            if (frame_valid) begin
              INTERLACE <= lines_differ_by_one;
              if (good_next >= LOCK_TARGET) begin
                state    <= ST_LOCKED;
                LOCKED   <= 1'b1;
                PAL_DET  <= (vlines_new >= PAL_MIN_LINES);
                good_cnt <= 4'd0;
              end else begin
                good_cnt <= good_next[3:0];
              end
            end else begin
              good_cnt  <= 4'd0;
              ERR_PULSE <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if ((vfall && !frame_valid) || (!vfall && vpos_sat)) begin
            state     <= ST_SEARCH;
            LOCKED    <= 1'b0;
            PAL_DET   <= 1'b0;
            INTERLACE <= 1'b0;
            ERR_PULSE <= 1'b1;
          end else if (vfall) begin
            INTERLACE <= lines_differ_by_one;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beam_sync_rx.sv
// tb_beam_sync_rx: directed-vector bench for beam_sync_rx using shortened
// lines (legal period 6..10 cycles) so that whole frames stay cheap.
module tb_beam_sync_rx;

  logic        pad_c28m;
  logic        pad_nrst;
  logic        pad_hsync;
  logic        pad_vsync;
  logic [11:0] hpos;
  logic [9:0]  vpos;
  logic [11:0] h_period;
  logic [9:0]  v_lines;
  logic        locked;
  logic        pal_det;
  logic        interlace;
  logic        err_pulse;

  int vectors          = 0;
  int miscompares      = 0;
  int cycle_cnt        = 0;
  int err_cnt          = 0;
  int err_base         = 0;
  int last_vsync_cycle = 0;
  int lock_rise_cycle  = -1;
  bit prev_locked      = 1'b0;

  beam_sync_rx #(
    .H_MIN      (6),
    .H_MAX      (10),
    .LOCK_COUNT (4)
  ) dut (
    .PAD_C28M  (pad_c28m),
    .PAD_NRST  (pad_nrst),
    .PAD_HSYNC (pad_hsync),
    .PAD_VSYNC (pad_vsync),
    .HPOS      (hpos),
    .VPOS      (vpos),
    .H_PERIOD  (h_period),
    .V_LINES   (v_lines),
    .LOCKED    (locked),
    .PAL_DET   (pal_det),
    .INTERLACE (interlace),
    .ERR_PULSE (err_pulse)
  );

  // 28 MHz master clock stand-in
  initial pad_c28m = 1'b0;
  always #5 pad_c28m = ~pad_c28m;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one cycle and record error strobes and the moment lock rises
  task automatic tick();
    @(negedge pad_c28m);
    cycle_cnt++;
    if (err_pulse === 1'b1) err_cnt++;
    if (locked === 1'b1 && !prev_locked) lock_rise_cycle = cycle_cnt;
    prev_locked = (locked === 1'b1);
  endtask

  // One line of len cycles; sync pads are low for the first two cycles
  task automatic applyStimulus(input int len, input bit vs);
    for (int c = 0; c < len; c++) begin
      pad_hsync = (c < 2) ? 1'b0 : 1'b1;
      pad_vsync = (vs && c < 2) ? 1'b0 : 1'b1;
      if (c == 0 && vs) last_vsync_cycle = cycle_cnt;
      tick();
    end
  endtask

  // n_lines lines alternating len_a/len_b, VSYNC on the first if first_vs
  task automatic applyFrame(input bit first_vs, input int n_lines,
                            input int len_a, input int len_b);
    for (int i = 0; i < n_lines; i++)
      applyStimulus((i % 2 == 0) ? len_a : len_b, first_vs && (i == 0));
  endtask

  initial begin
    pad_nrst  = 1'b0;
    pad_hsync = 1'b1;
    pad_vsync = 1'b1;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_hpos", 32'(hpos), 32'd0);
    checkOutput("rst_vpos", 32'(vpos), 32'd0);
    checkOutput("rst_hperiod", 32'(h_period), 32'd0);
    checkOutput("rst_vlines", 32'(v_lines), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_err", 32'(err_pulse), 32'd0);
    pad_nrst = 1'b1;

    // PAL progressive: 8-cycle lines, 313 lines, lock at the fifth VSYNC fall
    $display("[TB] PAL progressive");
    lock_rise_cycle = -1;
    repeat (5) applyFrame(1'b1, 313, 8, 8);
    checkOutput("pal_lock_latency", 32'(lock_rise_cycle - last_vsync_cycle), 32'd2);
    checkOutput("pal_locked", 32'(locked), 32'd1);
    checkOutput("pal_det", 32'(pal_det), 32'd1);
    checkOutput("pal_interlace", 32'(interlace), 32'd0);
    checkOutput("pal_vlines", 32'(v_lines), 32'd313);
    checkOutput("pal_hperiod", 32'(h_period), 32'd8);
    checkOutput("pal_vpos_end", 32'(vpos), 32'd312);
    checkOutput("pal_hpos_end", 32'(hpos), 32'd6);
    checkOutput("pal_no_err", 32'(err_cnt), 32'd0);

    // Coincident HSYNC and VSYNC fall
    $display("[TB] coincident sync edges");
    pad_hsync = 1'b0;
    pad_vsync = 1'b0;
    tick();
    checkOutput("coin_vpos_before", 32'(vpos), 32'd312);
    tick();
    checkOutput("coin_hpos", 32'(hpos), 32'd0);
    checkOutput("coin_vpos", 32'(vpos), 32'd0);
    checkOutput("coin_vlines", 32'(v_lines), 32'd313);
    pad_hsync = 1'b1;
    pad_vsync = 1'b1;
    repeat (6) tick();
    applyFrame(1'b0, 100, 8, 8);

    // Reset asserted mid-line while locked
    $display("[TB] reset mid-line");
    pad_hsync = 1'b0;
    tick();
    tick();
    pad_hsync = 1'b1;
    tick();
    checkOutput("pre_reset_locked", 32'(locked), 32'd1);
    pad_nrst = 1'b0;
    #1;
    checkOutput("mid_rst_locked", 32'(locked), 32'd0);
    checkOutput("mid_rst_pal", 32'(pal_det), 32'd0);
    checkOutput("mid_rst_hpos", 32'(hpos), 32'd0);
    checkOutput("mid_rst_vpos", 32'(vpos), 32'd0);
    checkOutput("mid_rst_hperiod", 32'(h_period), 32'd0);
    checkOutput("mid_rst_vlines", 32'(v_lines), 32'd0);
    repeat (3) tick();
    pad_nrst = 1'b1;

    // NTSC interlaced: 262/263-line frames, lines alternating 8/10 cycles
    $display("[TB] NTSC interlaced relock");
    lock_rise_cycle = -1;
    err_base = err_cnt;
    applyFrame(1'b1, 262, 8, 10);
    applyFrame(1'b1, 263, 8, 10);
    applyFrame(1'b1, 262, 8, 10);
    applyFrame(1'b1, 263, 8, 10);
    applyStimulus(8, 1'b1);
    checkOutput("ntsc_lock_latency", 32'(lock_rise_cycle - last_vsync_cycle), 32'd2);
    checkOutput("ntsc_locked", 32'(locked), 32'd1);
    checkOutput("ntsc_pal_det", 32'(pal_det), 32'd0);
    checkOutput("ntsc_interlace", 32'(interlace), 32'd1);
    checkOutput("ntsc_vlines", 32'(v_lines), 32'd263);
    checkOutput("ntsc_no_err", 32'(err_cnt - err_base), 32'd0);
    applyStimulus(10, 1'b0);
    checkOutput("ntsc_hperiod_a", 32'(h_period), 32'd8);
    applyStimulus(8, 1'b0);
    checkOutput("ntsc_hperiod_b", 32'(h_period), 32'd10);

    // VSYNC removed while locked: VPOS saturates, then lock is lost
    $display("[TB] VSYNC removed");
    applyFrame(1'b0, 700, 10, 8);
    checkOutput("novs_still_locked", 32'(locked), 32'd1);
    checkOutput("novs_vpos_mid", 32'(vpos), 32'd702);
    applyFrame(1'b0, 330, 10, 8);
    checkOutput("novs_vpos_sat", 32'(vpos), 32'd1023);
    checkOutput("novs_locked", 32'(locked), 32'd0);
    checkOutput("novs_interlace", 32'(interlace), 32'd0);
    checkOutput("novs_err_count", 32'(err_cnt - err_base), 32'd1);

    // Illegal 300-line frame while acquiring, then relock incl. a 6-cycle line
    $display("[TB] acquire with illegal frame");
    err_base = err_cnt;
    lock_rise_cycle = -1;
    applyFrame(1'b1, 300, 8, 8);
    applyStimulus(8, 1'b1);
    checkOutput("acq_bad_err", 32'(err_cnt - err_base), 32'd1);
    checkOutput("acq_bad_locked", 32'(locked), 32'd0);
    checkOutput("acq_bad_vlines", 32'(v_lines), 32'd300);
    applyFrame(1'b0, 312, 8, 8);
    applyFrame(1'b1, 313, 8, 8);
    applyStimulus(8, 1'b1);
    applyStimulus(6, 1'b0);
    applyFrame(1'b0, 311, 8, 8);
    applyFrame(1'b1, 313, 8, 8);
    err_base = err_cnt;
    applyStimulus(8, 1'b1);
    checkOutput("relock_latency", 32'(lock_rise_cycle - last_vsync_cycle), 32'd2);
    checkOutput("relock_pal_det", 32'(pal_det), 32'd1);
    checkOutput("relock_no_err", 32'(err_cnt - err_base), 32'd0);

    // Glitch while locked: one 5-cycle line, lock lost at the next frame end
    $display("[TB] glitch while locked");
    applyFrame(1'b0, 100, 8, 8);
    applyStimulus(5, 1'b0);
    applyStimulus(8, 1'b0);
    checkOutput("glitch_hperiod", 32'(h_period), 32'd5);
    checkOutput("glitch_still_locked", 32'(locked), 32'd1);
    applyFrame(1'b0, 210, 8, 8);
    applyStimulus(8, 1'b1);
    checkOutput("glitch_err_count", 32'(err_cnt - err_base), 32'd1);
    checkOutput("glitch_locked", 32'(locked), 32'd0);
    checkOutput("glitch_pal_det", 32'(pal_det), 32'd0);
    checkOutput("glitch_vlines", 32'(v_lines), 32'd313);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
